// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC stream buffers and core.
package ldpc_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned ADDR_WIDTH_DEF = 2;

    // Block buffer controller state, shared by the input and output buffers.
    typedef enum logic {
        BufFill = 1'b0,
        BufFull = 1'b1
    } buf_state_t;

endpackage

// File: rtl/streambuf_in.sv
// Input stream buffer: gathers 2**ADDR_WIDTH stream words into one parallel block.
module streambuf_in
    import ldpc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clr,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    output logic                                   blk_valid,
    input  logic                                   blk_ready,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]  blk_data,
    output logic [ADDR_WIDTH:0]                    wr_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LastSlot = ADDR_WIDTH'(DEPTH - 1);

    buf_state_t            state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  blk_valid_q, blk_valid_d;
    logic [ADDR_WIDTH:0]   wr_count_q, wr_count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic                  in_beat;
    logic                  blk_beat;
    logic [ADDR_WIDTH-1:0] slot;

    assign in_beat  = in_valid & in_ready_q;
    assign blk_beat = blk_valid_q & blk_ready;
    assign slot     = wr_count_q[ADDR_WIDTH-1:0];

    // Next state: clr beats a block beat, which beats an input beat (never both in practice).
    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        mem_d      = mem_q;
        if (clr) begin
            state_d    = BufFill;
            wr_count_d = '0;
        end else if (blk_beat) begin
            // Storage is kept; the next block overwrites it slot by slot.
            state_d    = BufFill;
            wr_count_d = '0;
        end else if (in_beat) begin
            mem_d[slot] = in_data;
            wr_count_d  = wr_count_q + 1'b1;
            if (slot == LastSlot) begin
                state_d = BufFull;
            end
        end
        // Handshake outputs are registered decodes of the next state.
        in_ready_d  = (state_d == BufFill);
        blk_valid_d = (state_d == BufFull);
    end

    // State, counter, storage and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BufFill;
            in_ready_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            wr_count_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            blk_valid_q <= blk_valid_d;
            wr_count_q  <= wr_count_d;
            mem_q       <= mem_d;
        end
    end

    // Flatten the slot array; slot k sits at bits [k*DATA_WIDTH +: DATA_WIDTH].
    always_comb begin
        blk_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            blk_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k];
        end
    end

    assign in_ready  = in_ready_q;
    assign blk_valid = blk_valid_q;
    assign wr_count  = wr_count_q;

endmodule

// File: doc/streambuf_in.md
# streambuf_in

Input stream buffer that collects a block of `2**ADDR_WIDTH` words arriving one per beat on a valid/ready stream. It presents the whole block as one parallel word to the LDPC core. It is the upstream neighbour of the core: the core consumes the parallel block, and its results leave through the output stream buffer. Flow control on both sides is valid/ready, so the block never drops or duplicates a word.

## Interface

Parameters:
- `DATA_WIDTH`, 16: width of one stream word.
- `ADDR_WIDTH`, 2: log2 of words per block; `DEPTH = 2**ADDR_WIDTH`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset. Asserting low clears all state immediately; release is synchronous to `clk`.
- `clr`, input, 1: synchronous abort. Discards the partial or complete block and returns to FILL.
- `in_valid`, input, 1: `in_data` holds a word.
- `in_ready`, output, 1: buffer accepts a word this cycle.
- `in_data`, input, `DATA_WIDTH`: stream word.
- `blk_valid`, output, 1: `blk_data` holds a complete block.
- `blk_ready`, input, 1: core takes the block this cycle.
- `blk_data`, output, `DEPTH*DATA_WIDTH`: word k at bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `wr_count`, output, `ADDR_WIDTH+1`: words held, 0..DEPTH.

## Operation

- Two states:
  - FILL: `in_ready=1`, `blk_valid=0`.
  - FULL: `in_ready=0`, `blk_valid=1`.
- Input beat: `in_valid & in_ready` at a rising edge.
  - Stores `in_data` at slot `wr_count[ADDR_WIDTH-1:0]`.
  - Increments `wr_count`.
- FILL -> FULL: on the beat that stores slot DEPTH-1. `wr_count` becomes DEPTH.
- Block beat: `blk_valid & blk_ready` at a rising edge.
  - FULL -> FILL.
  - `wr_count` -> 0.
- Storage hold rules:
  - Storage is not cleared on the block beat. Slots are overwritten by the next block.
  - `blk_data` is stable for the whole FULL state.
- `in_valid` in FULL is ignored. No write happens and the word stays on the upstream side.
- `blk_ready` in FILL is ignored.
- `clr` has priority over both beats in the same cycle. Result: FILL, `wr_count=0`, no write.
- Reset values: state FILL, `wr_count=0`, `in_ready=1` after reset release (0 while `rst` is low), `blk_valid=0`, `blk_data` all zero.
- Reset mid-block: the partial block is lost. The next accepted word goes to slot 0.
- No bypass: a block beat and an input beat never coincide, because `in_ready=0` in FULL.

## Timing

- `in_ready` and `blk_valid` are registered state decodes. There is no combinational path from `blk_ready` or `in_valid` to any output.
- Latency from the edge that accepts word DEPTH-1 to `blk_valid=1`: the same edge, i.e. visible next cycle.
- Minimum period per block is DEPTH+1 cycles: DEPTH input beats plus one block beat.
  - With `blk_ready` tied high, `in_ready` is low for exactly one cycle per block.
- After a block beat, `in_ready=1` from the next cycle on.
- `wr_count` width is `ADDR_WIDTH+1`, so DEPTH is representable. The slot index is its low `ADDR_WIDTH` bits. It never exceeds DEPTH.

## Structure

- Shared package `ldpc_pkg`:
  - default `DATA_WIDTH`/`ADDR_WIDTH` constants;
  - the `buf_state_t` FILL/FULL encoding, reused by the output buffer's controller.
- No sub-module is required. The slot counter and FSM are inline, because the shared `counter` uses an active-high reset and has no enable-gated increment.
- Storage is a register array flattened onto `blk_data`.

## Test plan

Bench uses `DATA_WIDTH=16`, `ADDR_WIDTH=2`.

1. Reset then fill: `rst` low 3 cycles, then words 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles with `blk_ready=0`.
   - Required: `blk_valid=1` the cycle after the 4th beat.
   - Required: `blk_data=0x4444_3333_2222_1111`, `in_ready=0`, `wr_count=4`.
2. Backpressure: hold `blk_ready=0` for 10 cycles in FULL and drive 0xDEAD with `in_valid=1`.
   - Required: `blk_data` unchanged, `wr_count=4`.
   - Then `blk_ready=1` for 1 cycle: FILL, `wr_count=0`, `in_ready=1` next cycle; 0xDEAD is the first word of the next block.
3. Streaming: `in_valid` and `blk_ready` tied high for 3 blocks of incrementing words 0x0000..0x000B.
   - Required: exactly 3 block beats, each 5 cycles apart, words in order.
4. Gapped input: `in_valid` toggled 1,0,0,1,1,0,1.
   - Required: only 4 beats stored, in slot order 0..3.
5. `clr` after 2 beats, asserted in the same cycle as a 3rd `in_valid`.
   - Required: `wr_count=0`, no write; the next word lands in slot 0.
6. Async reset pulse mid-FULL, not aligned to `clk`.
   - Required: `blk_valid` drops immediately, `blk_data=0`, `wr_count=0`.
